// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging blocks (trigger generator,
// echo meter, top-level controller).
//   - meter_state_e : measurement FSM states
//   - DEFAULT_*     : default timing constants for a 50 MHz system clock
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } meter_state_e;

  localparam int DEFAULT_CLK_HZ       = 50_000_000;
  // 58 us of echo per cm of range (sound travels out and back) at 50 MHz.
  localparam int DEFAULT_TICKS_PER_CM = 2900;
  localparam int DEFAULT_MAX_CM       = 400;
  localparam int DEFAULT_RISE_TIMEOUT = 50000;

endpackage

// File: rtl/echo_meter_if.sv
// Bus between the echo meter and the surrounding control/sensor logic.
//   start     : 1-cycle measurement request (driven alongside the trigger)
//   echo      : raw sensor echo pin, asynchronous to the system clock
//   distance  : last measured range in cm
//   valid     : 1-cycle strobe, distance/status updated
//   busy      : measurement in progress
//   no_echo   : last result had no echo rise before the timeout
//   overrange : last result saturated at the maximum distance
// Modports: master = controller/sensor side, slave = echo meter.
interface echo_meter_if #(
  parameter int DIST_W = 9
) ();

  logic              start;
  logic              echo;
  logic [DIST_W-1:0] distance;
  logic              valid;
  logic              busy;
  logic              no_echo;
  logic              overrange;

  modport master (
    output start, echo,
    input  distance, valid, busy, no_echo, overrange
  );

  modport slave (
    input  start, echo,
    output distance, valid, busy, no_echo, overrange
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by an edge
// detector on the synchronized signal.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears all flops
//   sig_i   : asynchronous input
//   sig_s_o : synchronized level (second flop)
//   rise_o  : sig_s_o is 1 and was 0 on the previous cycle
//   fall_o  : sig_s_o is 0 and was 1 on the previous cycle
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sig_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sig_s_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/echo_meter.sv
// Times the ultrasonic sensor's echo pulse after a trigger and converts the
// width into whole centimetres, with explicit no-echo and overrange status.
//   CLKOUT1 : system clock
//   reset   : synchronous active-high reset, aborts any measurement
//   bus     : echo_meter_if slave (start/echo in; distance, valid, busy,
//             no_echo, overrange out -- all outputs registered)
module echo_meter
  import ultrasonic_pkg::*;
#(
  parameter int TICKS_PER_CM = DEFAULT_TICKS_PER_CM,
  parameter int MAX_CM       = DEFAULT_MAX_CM,
  parameter int DIST_W       = 9,
  parameter int RISE_TIMEOUT = DEFAULT_RISE_TIMEOUT
) (
  input  logic         CLKOUT1,
  input  logic         reset,
  echo_meter_if.slave  bus
);

  localparam int TMO_W = $clog2(RISE_TIMEOUT);
  localparam int PRE_W = $clog2(TICKS_PER_CM);

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RISE_TIMEOUT - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX   = DIST_W'(MAX_CM);

  logic echo_s_unused;
  logic echo_rise;
  logic echo_fall;

  sync_edge u_sync (
    .clk_i   (CLKOUT1),
    .rst_i   (reset),
    .sig_i   (bus.echo),
    .sig_s_o (echo_s_unused),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  meter_state_e      state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [PRE_W-1:0]  pre_q;
  logic [DIST_W-1:0] cm_q;
  logic [DIST_W-1:0] distance_q;
  logic              valid_q;
  logic              busy_q;
  logic              no_echo_q;
  logic              overrange_q;

  // Prescaler/cm values after counting the current MEASURE cycle. The cycle
  // that sees the synchronized fall is still counted: the synchronizer
  // delays both edges equally, so this makes an N-cycle echo count N ticks.
  logic              pre_wrap;
  logic [PRE_W-1:0]  pre_d;
  logic [DIST_W-1:0] cm_d;

  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
    cm_d     = pre_wrap ? cm_q + 1'b1 : cm_q;
  end

  always_ff @(posedge CLKOUT1) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      pre_q       <= '0;
      cm_q        <= '0;
      distance_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      no_echo_q   <= 1'b0;
      overrange_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= WAIT_RISE;
            tmo_q   <= '0;
            pre_q   <= '0;
            cm_q    <= '0;
            busy_q  <= 1'b1;
          end
        end

        WAIT_RISE: begin
          // Only a real low-to-high transition counts, so an echo that is
          // still high from a previous ping is ignored until it drops.
          if (echo_rise) begin
            state_q <= MEASURE;
            pre_q   <= '0;
            cm_q    <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= DONE;
            distance_q  <= '0;
            no_echo_q   <= 1'b1;
            overrange_q <= 1'b0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        MEASURE: begin
          pre_q <= pre_d;
          cm_q  <= cm_d;
          // cm_q never exceeds MAX_CM-1 here, so reaching MAX_CM implies a
          // wrap this cycle; it is checked first so it beats a coincident fall.
          if (cm_d == CM_MAX) begin
            state_q     <= DONE;
            distance_q  <= CM_MAX;
            no_echo_q   <= 1'b0;
            overrange_q <= 1'b1;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
          end else if (echo_fall) begin
            state_q     <= DONE;
            distance_q  <= cm_d;
            no_echo_q   <= 1'b0;
            overrange_q <= 1'b0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.distance  = distance_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.no_echo   = no_echo_q;
  assign bus.overrange = overrange_q;

endmodule

// File: tb/tb_echo_meter.sv
module tb_echo_meter;

  localparam int TPC  = 10;
  localparam int MAXC = 20;
  localparam int RTO  = 50;
  localparam int DW   = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  echo_meter_if #(.DIST_W(DW)) bus ();

  echo_meter #(
    .TICKS_PER_CM (TPC),
    .MAX_CM       (MAXC),
    .DIST_W       (DW),
    .RISE_TIMEOUT (RTO)
  ) dut (
    .CLKOUT1 (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // stale: cycles echo stays high (already high before start) from cycle 0
  // d/w  : echo rises at cycle 1+d for w cycles (w=0: never)
  // extra: cycle of a second start pulse (-1: none)
  // tick : expected cycle (after start sample) on which valid is seen
  typedef struct {
    string name;
    int    stale;
    int    d;
    int    w;
    int    extra;
    int    exp_dist;
    int    exp_ne;
    int    exp_ov;
    int    exp_tick;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    int n;
    int vcount;
    int vt;
    int busy_bad;
    int got_dist;
    int got_ne;
    int got_ov;
    if (v.stale > 0) begin
      bus.echo = 1'b1;
      repeat (4) tick();
    end
    n = v.exp_tick;
    if (1 + v.d + v.w + 5 > n) n = 1 + v.d + v.w + 5;
    n = n + 6;
    vcount = 0; vt = -1; busy_bad = 0;
    got_dist = -1; got_ne = -1; got_ov = -1;
    for (int c = 0; c < n; c++) begin
      bus.start = (c == 0) || (c == v.extra);
      bus.echo  = (c < v.stale) || (v.w > 0 && c >= 1 + v.d && c < 1 + v.d + v.w);
      tick();
      if (bus.busy !== ((c + 1) < v.exp_tick)) busy_bad++;
      if (bus.valid === 1'b1) begin
        vcount++;
        if (vt < 0) begin
          vt       = c + 1;
          got_dist = int'(bus.distance);
          got_ne   = int'(bus.no_echo);
          got_ov   = int'(bus.overrange);
        end
      end
    end
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    $display("vec %s: valid@%0d count=%0d dist=%0d no_echo=%0d overrange=%0d",
             v.name, vt, vcount, got_dist, got_ne, got_ov);
    check({v.name, ".valid_count"}, vcount, 1);
    check({v.name, ".valid_cycle"}, vt, v.exp_tick);
    check({v.name, ".distance"}, got_dist, v.exp_dist);
    check({v.name, ".no_echo"}, got_ne, v.exp_ne);
    check({v.name, ".overrange"}, got_ov, v.exp_ov);
    check({v.name, ".busy_profile_errs"}, busy_bad, 0);
    check({v.name, ".hold_distance"}, int'(bus.distance), v.exp_dist);
    check({v.name, ".hold_flags"}, {bus.no_echo, bus.overrange},
          {v.exp_ne[0], v.exp_ov[0]});
  endtask

  initial begin
    int vbad;
    int bbad;

    //          name         stale d   w    extra dist ne ov tick
    vecs[0]  = '{"normal73",   0,  5,  73,  -1,   7,  0, 0,  82};
    vecs[1]  = '{"width9",     0,  2,   9,  -1,   0,  0, 0,  15};
    vecs[2]  = '{"width10",    0,  2,  10,  -1,   1,  0, 0,  16};
    vecs[3]  = '{"width19",    0,  1,  19,  -1,   1,  0, 0,  24};
    vecs[4]  = '{"width20",    0,  1,  20,  -1,   2,  0, 0,  25};
    vecs[5]  = '{"no_echo",    0,  0,   0,  -1,   0,  1, 0,  51};
    vecs[6]  = '{"over500",    0,  4, 500,  -1,  20,  0, 1, 208};
    vecs[7]  = '{"width199",   0,  2, 199,  -1,  19,  0, 0, 205};
    vecs[8]  = '{"width200",   0,  2, 200,  -1,  20,  0, 1, 206};
    vecs[9]  = '{"start_busy", 0,  5,  73,  40,   7,  0, 0,  82};
    vecs[10] = '{"stale_echo", 8, 12,  30,  -1,   3,  0, 0,  46};
    vecs[11] = '{"repeat73",   0,  5,  73,  -1,   7,  0, 0,  82};

    // Reset state
    rst = 1'b1; bus.start = 1'b0; bus.echo = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset.distance", bus.distance, 0);
    check("reset.valid", bus.valid, 0);
    check("reset.busy", bus.busy, 0);
    check("reset.no_echo", bus.no_echo, 0);
    check("reset.overrange", bus.overrange, 0);

    run_vec(vecs[0]);

    // Reset in the middle of a measurement, then the echo falls later
    vbad = 0; bbad = 0;
    for (int c = 0; c < 60; c++) begin
      bus.start = (c == 0);
      bus.echo  = (c >= 3 && c < 43);
      rst       = (c == 30);
      tick();
      if (c == 30) begin
        check("mid_reset.busy", bus.busy, 0);
        check("mid_reset.valid", bus.valid, 0);
        check("mid_reset.distance", bus.distance, 0);
        check("mid_reset.flags", {bus.no_echo, bus.overrange}, 0);
      end
      if (c > 30) begin
        if (bus.valid !== 1'b0) vbad++;
        if (bus.busy !== 1'b0) bbad++;
      end
    end
    rst = 1'b0; bus.start = 1'b0; bus.echo = 1'b0;
    $display("seq mid_reset: late valids=%0d busy cycles=%0d", vbad, bbad);
    check("mid_reset.no_late_valid", vbad, 0);
    check("mid_reset.idle_after", bbad, 0);

    // start in the same cycle as reset is ignored
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    bbad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) bbad++;
    end
    $display("seq start_with_reset: active cycles=%0d", bbad);
    check("start_with_reset.ignored", bbad, 0);

    // Echo pulse while idle does nothing
    bbad = 0;
    for (int c = 0; c < 30; c++) begin
      bus.echo = (c < 15);
      tick();
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) bbad++;
    end
    bus.echo = 1'b0;
    $display("seq idle_echo: active cycles=%0d", bbad);
    check("idle_echo.ignored", bbad, 0);
    check("idle_echo.distance_held", bus.distance, 0);

    for (int i = 1; i < 12; i++) run_vec(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
